fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QDEPTH, default 2, SHALL set instruction-queue entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  current PC from the pc register.
REQ-005 nextPC  output  32  value the pc register SHALL load on the next edge.
REQ-006 redirect  input  1  branch/jump taken; flush and refetch.
REQ-007 redirectPC  input  32  redirect target.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts request.
REQ-010 imem_req_addr  output  32  fetch address; SHALL equal addr.
REQ-011 imem_rsp_valid  input  1  response valid; in-order, at most one outstanding.
REQ-012 imem_rsp_data  input  32  fetched instruction word.
REQ-013 out_valid  output  1  instruction available to decode.
REQ-014 out_ready  input  1  decode accepts instruction.
REQ-015 out_instr  output  32  instruction at queue head.
REQ-016 out_pc  output  32  PC of out_instr.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP.
REQ-018 IDLE->REQ when queue count + outstanding < QDEPTH; REQ->WAIT on req handshake; WAIT->REQ on response if space remains, else ->IDLE; DROP->REQ on response.
REQ-019 imem_req_valid SHALL be high only in REQ and SHALL be low in any cycle redirect is high.
REQ-020 On req handshake, request addr SHALL be captured as reqPC and nextPC SHALL be addr+4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 Without handshake or redirect, nextPC SHALL equal addr (hold).
REQ-022 On redirect, nextPC SHALL be {redirectPC[31:2],2'b00}; redirect has priority over every other event.
REQ-023 On redirect, queue SHALL flush at that edge; out_valid SHALL be 0 the following cycle.
REQ-024 Redirect in WAIT, or coinciding with a response-free cycle with one outstanding, SHALL go to DROP; otherwise ->REQ.
REQ-025 Redirect coinciding with a response SHALL discard that response and go to REQ.
REQ-026 In DROP, the arriving response SHALL be discarded, never enqueued.
REQ-027 Response in WAIT SHALL enqueue {reqPC, imem_rsp_data}.
REQ-028 Dequeue SHALL occur when out_valid && out_ready; simultaneous enqueue and dequeue on a full queue SHALL be legal and keep count unchanged.
REQ-029 Queue SHALL never overflow; request gating per REQ-018 guarantees space.
REQ-030 out_instr/out_pc SHALL be stable while out_valid && !out_ready.

Reset
REQ-031 While reset high: state IDLE, queue empty, no outstanding, imem_req_valid=0, out_valid=0, nextPC=0x00000000.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; a response arriving during or after reset before any new request SHALL be ignored.
REQ-033 First request SHALL be issued no earlier than the cycle after reset deasserts.

Configuration
REQ-034 Macro FETCH_BYPASS_EN defined: response arriving with queue empty SHALL drive out_valid/out_instr/out_pc combinationally that cycle; if out_ready is high it SHALL not be enqueued, otherwise it SHALL be enqueued.
REQ-035 FETCH_BYPASS_EN undefined: out_valid SHALL rise exactly one cycle after the enqueuing response.

Verification
REQ-036 Reset, addr=0, imem ready, 1-cycle response 0x00000013, out_ready=1 -> nextPC=0x4 at handshake; out_instr=0x00000013, out_pc=0x0.
REQ-037 Three sequential fetches from 0x0, out_ready=0 -> queue holds PCs 0x0,0x4; no third request until out_ready=1.
REQ-038 Redirect to 0x40 while WAIT for 0x8 -> response for 0x8 discarded; next request addr=0x40; first out_pc=0x40.
REQ-039 addr=0xFFFFFFFC handshake -> nextPC=0x00000000; redirectPC=0x43 -> nextPC=0x40.
REQ-040 Reset asserted in WAIT, response arrives during reset -> out_valid stays 0; fetch restarts at 0x0.
REQ-041 Empty queue, response 0xDEADBEEF, out_ready=1 -> out_valid same cycle with FETCH_BYPASS_EN, next cycle without.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : PC-driven instruction fetch with in-order imem handshake, redirect
//           flush and a small instruction queue. Optional macro FETCH_BYPASS_EN
//           forwards a response straight to decode when the queue is empty.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  output logic [31:0] nextPC,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned C_PTR_W = $clog2(QDEPTH);
  localparam int unsigned C_CNT_W = C_PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          req_pc_q, req_pc_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_PTR_W-1:0]   head_q, head_d;
  logic [C_PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]          instr_mem_q [QDEPTH];
  logic [31:0]          pc_mem_q    [QDEPTH];

  logic w_outstanding;
  logic w_hs;
  logic w_rsp_wait;
  logic w_byp;
  logic w_q_valid;
  logic w_enq;
  logic w_deq;
  logic w_space_now;
  logic w_space_after;
  logic w_unused_rpc;

  assign w_unused_rpc  = &{1'b0, redirectPC[1:0]};

  assign w_outstanding = (state_q == WAIT) || (state_q == DROP);
  assign imem_req_valid = (state_q == REQ) && !redirect && !reset;
  assign imem_req_addr  = addr;
  assign w_hs           = imem_req_valid && imem_req_ready;

  // Only a response for a live request in WAIT is kept; DROP/IDLE/REQ ignore it.
  assign w_rsp_wait = (state_q == WAIT) && imem_rsp_valid && !redirect && !reset;
  assign w_q_valid  = (cnt_q != '0);

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_rsp_wait && !w_q_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign out_valid = !reset && (w_q_valid || w_byp);
  assign out_instr = w_q_valid ? instr_mem_q[head_q] : imem_rsp_data;
  assign out_pc    = w_q_valid ? pc_mem_q[head_q]    : req_pc_q;

  assign w_deq = !reset && w_q_valid && out_ready;
  assign w_enq = w_rsp_wait && !(w_byp && out_ready);

  assign w_space_now   = (cnt_q + C_CNT_W'(w_outstanding)) < C_CNT_W'(QDEPTH);
  assign w_space_after = cnt_d < C_CNT_W'(QDEPTH);

  always_comb begin
    if (reset) begin
      nextPC = 32'h0000_0000;
    end else if (redirect) begin
      nextPC = {redirectPC[31:2], 2'b00};
    end else if (w_hs) begin
      nextPC = addr + 32'd4;
    end else begin
      nextPC = addr;
    end
  end

  always_comb begin
    req_pc_d = w_hs ? addr : req_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_enq) tail_d = tail_q + 1'b1;
      if (w_deq) head_d = head_q + 1'b1;
      cnt_d = cnt_q + C_CNT_W'(w_enq) - C_CNT_W'(w_deq);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (w_space_now) state_d = REQ;
      REQ:     if (w_hs) state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = w_space_after ? REQ : IDLE;
      DROP:    if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    // A request still in flight must be drained before refetching.
    if (redirect) begin
      state_d = (w_outstanding && !imem_rsp_valid) ? DROP : REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_pc_q <= 32'h0000_0000;
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      instr_mem_q[tail_q] <= imem_rsp_data;
      pc_mem_q[tail_q]    <= req_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed self-checking bench for fetch_unit; models the pc register.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] nextPC;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FETCH_BYPASS_EN
  localparam logic [31:0] C_BYP = 32'd1;
`else
  localparam logic [31:0] C_BYP = 32'd0;
`endif

  fetch_unit #(.QDEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr           (addr),
    .nextPC         (nextPC),
    .redirect       (redirect),
    .redirectPC     (redirectPC),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; the pc register loads nextPC at the edge.
  task automatic tick();
    logic [31:0] pc_next;
    #1;
    pc_next = nextPC;
    @(posedge clk);
    #1;
    addr = pc_next;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (imem_req_valid) seen = 1'b1;
      else tick();
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_req;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    settle();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_nextpc", nextPC, 32'h0);

    // Single fetch from 0x0, decode ready
    reset = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    wait_req("t1_req_seen");
    check("t1_req_addr", imem_req_addr, 32'h0);
    check("t1_nextpc_hs", nextPC, 32'h4);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    settle();
    check("t1_nextpc_hold", nextPC, 32'h4);
    check("t1_valid_rsp_cycle", {31'd0, out_valid}, C_BYP);
`ifdef FETCH_BYPASS_EN
    check("t1_byp_instr", out_instr, 32'h0000_0013);
    check("t1_byp_pc", out_pc, 32'h0);
`endif
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    settle();
    check("t1_valid_next_cycle", {31'd0, out_valid}, 32'd1 - C_BYP);
`ifndef FETCH_BYPASS_EN
    check("t1_instr", out_instr, 32'h0000_0013);
    check("t1_pc", out_pc, 32'h0);
`endif
    check("t1_req2_addr", imem_req_addr, 32'h4);
    check("t1_nextpc_noready", nextPC, 32'h4);

    // Queue fill with decode stalled
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b1;
    wait_req("t2_req0_seen");
    check("t2_req0_addr", imem_req_addr, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("t2_req1_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t2_req1_addr", imem_req_addr, 32'h4);
    check("t2_head_pc0", out_pc, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
    settle();
    check("t2_head_stable", out_pc, 32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    any_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      any_req |= imem_req_valid;
      tick();
    end
    check("t2_no_third_req", {31'd0, any_req}, 32'd0);
    out_ready = 1'b1;
    settle();
    check("t2_full_valid", {31'd0, out_valid}, 32'd1);
    check("t2_full_pc0", out_pc, 32'h0);
    check("t2_full_instr0", out_instr, 32'h0000_0013);
    tick();
    out_ready = 1'b0;
    settle();
    check("t2_head_pc4", out_pc, 32'h4);
    check("t2_head_instr4", out_instr, 32'h0000_0413);
    wait_req("t2_req2_seen");
    check("t2_req2_addr", imem_req_addr, 32'h8);

    // Redirect while waiting on 0x8
    tick();
    redirect = 1'b1; redirectPC = 32'h0000_0043;
    settle();
    check("t3_redir_nextpc", nextPC, 32'h40);
    check("t3_redir_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0813;
    settle();
    check("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    check("t3_drop_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    settle();
    check("t3_refetch_valid", {31'd0, imem_req_valid}, 32'd1);
    check("t3_refetch_addr", imem_req_addr, 32'h40);
    check("t3_drop_discarded", {31'd0, out_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_4013; out_ready = 1'b1;
    settle();
    check("t3_rsp_cycle_valid", {31'd0, out_valid}, C_BYP);
`ifdef FETCH_BYPASS_EN
    check("t3_byp_pc", out_pc, 32'h40);
`endif
    tick();
    imem_rsp_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
    settle();
    check("t3_next_cycle_valid", {31'd0, out_valid}, 32'd1 - C_BYP);
`ifndef FETCH_BYPASS_EN
    check("t3_first_pc", out_pc, 32'h40);
    check("t3_first_instr", out_instr, 32'h0000_4013);
`endif

    // PC wrap, redirect coinciding with response, bypass word
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; imem_req_ready = 1'b1;
    settle();
    check("t4_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("t4_wrap_nextpc", nextPC, 32'h0);
    check("t4_flushed", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b1; redirectPC = 32'h0000_0103;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111; out_ready = 1'b1;
    settle();
    check("t4_redir_rsp_nextpc", nextPC, 32'h100);
    check("t4_redir_rsp_valid", {31'd0, out_valid}, 32'd0);
    tick();
    redirect = 1'b0; imem_rsp_valid = 1'b0;
    settle();
    check("t4_req_after_discard", {31'd0, imem_req_valid}, 32'd1);
    check("t4_req_addr_100", imem_req_addr, 32'h100);
    check("t4_discarded_valid", {31'd0, out_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    settle();
    check("t4_beef_same_cycle", {31'd0, out_valid}, C_BYP);
`ifdef FETCH_BYPASS_EN
    check("t4_beef_byp_instr", out_instr, 32'hDEAD_BEEF);
    check("t4_beef_byp_pc", out_pc, 32'h100);
`endif
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    settle();
    check("t4_beef_next_cycle", {31'd0, out_valid}, 32'd1 - C_BYP);
`ifndef FETCH_BYPASS_EN
    check("t4_beef_instr", out_instr, 32'hDEAD_BEEF);
    check("t4_beef_pc", out_pc, 32'h100);
`endif
    tick();
    settle();
    check("t4_drained", {31'd0, out_valid}, 32'd0);

    // Reset while waiting, response during and after reset
    imem_req_ready = 1'b1;
    tick();
    reset = 1'b1;
    settle();
    check("t5_rst_noreq", {31'd0, imem_req_valid}, 32'd0);
    check("t5_rst_nextpc", nextPC, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0055;
    settle();
    check("t5_rsp_in_rst", {31'd0, out_valid}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check("t5_rsp_after_rst", {31'd0, out_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    wait_req("t5_restart_seen");
    check("t5_restart_addr", imem_req_addr, 32'h0);
    check("t5_still_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
